cmi_enc: RTL and testbench

CMI_ENC -- requirements
Module: cmi_enc

---
 rtl/cmi_enc.sv | 126 ++++++++++++
 tb/tb_cmi_enc.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmi_enc.sv
// rtl/cmi_enc.sv - CMI (coded mark inversion) byte serializer with valid/ready input.
// Optional serial NRZ output line_sig is enabled by defining CMI_ENC_LINE_OUT_EN.
module cmi_enc #(
  parameter int BIT_DIV   = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic       clk_sig,
  input  logic       reset_sig,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [1:0] encode_sig,
  output logic       encode_valid,
  output logic       busy
`ifdef CMI_ENC_LINE_OUT_EN
  ,
  output logic       line_sig
`endif
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  localparam logic [7:0] LAST_CNT = 8'(BIT_DIV - 1);

  if (BIT_DIV < 2 || BIT_DIV > 255) begin : g_bad_div
    $error("cmi_enc: BIT_DIV must be in 2..255");
  end

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic [1:0] sym_q, sym_d;
  logic       mark_q, mark_d;
  logic       rdy_en_q;
  logic       accept, bit_end, byte_end, load, nbit;

  function automatic logic pick(input logic [7:0] b, input logic [2:0] i);
    return (MSB_FIRST != 0) ? b[3'd7 - i] : b[i];
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    sym_d    = sym_q;
    mark_d   = mark_q;
    load     = 1'b0;
    nbit     = 1'b0;
    bit_end  = (cnt_q == LAST_CNT);
    byte_end = (state_q == SEND) && bit_end && (idx_q == 3'd7);
    // rdy_en_q holds ready low until the first edge after reset release
    data_ready = rdy_en_q && ((state_q == IDLE) || byte_end);
    accept     = data_valid && data_ready;

    if (accept) begin
      state_d = SEND;
      cnt_d   = 8'd0;
      idx_d   = 3'd0;
      data_d  = data_in;
      nbit    = pick(data_in, 3'd0);
      load    = 1'b1;
    end else if (state_q == SEND) begin
      if (bit_end) begin
        cnt_d = 8'd0;
        if (idx_q == 3'd7) begin
          state_d = IDLE;
          idx_d   = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
          nbit  = pick(data_q, idx_q + 3'd1);
          load  = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    // A 1-bit alternates between 11 and 00; the mark flag survives idle gaps
    if (load) begin
      if (nbit) begin
        sym_d  = mark_q ? 2'b00 : 2'b11;
        mark_d = ~mark_q;
      end else begin
        sym_d = 2'b01;
      end
    end
  end

  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= 3'd0;
      data_q   <= 8'd0;
      sym_q    <= 2'b01;
      mark_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      sym_q    <= sym_d;
      mark_q   <= mark_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign encode_valid = (state_q == SEND);
  assign busy         = (state_q == SEND);
  assign encode_sig   = (state_q == SEND) ? sym_q : 2'b01;

`ifdef CMI_ENC_LINE_OUT_EN
  localparam logic [7:0] HALF_CNT = 8'(BIT_DIV / 2);

  if ((BIT_DIV % 2) != 0) begin : g_odd_div
    $error("cmi_enc: BIT_DIV must be even when line_sig is enabled");
  end

  assign line_sig = (state_q != SEND) ? 1'b0 :
                    (cnt_q < HALF_CNT) ? sym_q[1] : sym_q[0];
`endif

endmodule

// File: tb/tb_cmi_enc.sv
// tb/tb_cmi_enc.sv - scoreboard bench for cmi_enc: MSB-first/BIT_DIV=4 and LSB-first/BIT_DIV=2 instances.
// line_sig is checked when CMI_ENC_LINE_OUT_EN is defined.
module tb_cmi_enc;

  localparam int BD0 = 4;
  localparam int BD1 = 2;

  typedef struct {
    logic [1:0] sym;
    bit         last;
    bit         line;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din[2];
  logic       dval[2];
  logic       drdy[2];
  logic [1:0] esig[2];
  logic       evld[2];
  logic       bsy[2];
`ifdef CMI_ENC_LINE_OUT_EN
  logic       lin[2];
`endif

  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  bit   mark_m[2];
  ent_t sq[2][$];
  logic [1:0] cap[2][$];

  always #5 clk = ~clk;

  cmi_enc #(.BIT_DIV(BD0), .MSB_FIRST(1)) u_msb (
    .clk_sig(clk), .reset_sig(rst_n), .data_in(din[0]), .data_valid(dval[0]),
    .data_ready(drdy[0]), .encode_sig(esig[0]), .encode_valid(evld[0]), .busy(bsy[0])
`ifdef CMI_ENC_LINE_OUT_EN
    , .line_sig(lin[0])
`endif
  );

  cmi_enc #(.BIT_DIV(BD1), .MSB_FIRST(0)) u_lsb (
    .clk_sig(clk), .reset_sig(rst_n), .data_in(din[1]), .data_valid(dval[1]),
    .data_ready(drdy[1]), .encode_sig(esig[1]), .encode_valid(evld[1]), .busy(bsy[1])
`ifdef CMI_ENC_LINE_OUT_EN
    , .line_sig(lin[1])
`endif
  );

  function automatic int bd(int i);
    return (i == 0) ? BD0 : BD1;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: each data bit becomes bd() identical per-clock entries
  task automatic push_byte(int i, logic [7:0] b);
    bit         v;
    logic [1:0] s;
    ent_t       e;
    for (int k = 0; k < 8; k++) begin
      v = (i == 0) ? b[7 - k] : b[k];
      if (v) begin
        s = mark_m[i] ? 2'b00 : 2'b11;
        mark_m[i] = !mark_m[i];
      end else begin
        s = 2'b01;
      end
      for (int c = 0; c < bd(i); c++) begin
        e.sym  = s;
        e.last = (k == 7) && (c == bd(i) - 1);
        e.line = (c < bd(i) / 2) ? s[1] : s[0];
        sq[i].push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (evld[i]) begin
          cap[i].push_back(esig[i]);
          chk($sformatf("busy_send%0d", i), bsy[i], 1);
          if (sq[i].size() == 0) begin
            chk($sformatf("unexpected_valid%0d", i), 1, 0);
          end else begin
            e = sq[i].pop_front();
            chk($sformatf("sym%0d", i), esig[i], e.sym);
            chk($sformatf("ready_send%0d", i), drdy[i], e.last);
`ifdef CMI_ENC_LINE_OUT_EN
            chk($sformatf("line_send%0d", i), lin[i], e.line);
`endif
          end
        end else begin
          chk($sformatf("idle_sym%0d", i), esig[i], 2'b01);
          chk($sformatf("idle_busy%0d", i), bsy[i], 0);
          chk($sformatf("idle_ready%0d", i), drdy[i], 1);
          chk($sformatf("pending_in_idle%0d", i), sq[i].size(), 0);
`ifdef CMI_ENC_LINE_OUT_EN
          chk($sformatf("idle_line%0d", i), lin[i], 0);
`endif
        end
      end
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_sym%0d", i), esig[i], 2'b01);
      chk($sformatf("rst_valid%0d", i), evld[i], 0);
      chk($sformatf("rst_busy%0d", i), bsy[i], 0);
      chk($sformatf("rst_ready%0d", i), drdy[i], 0);
`ifdef CMI_ENC_LINE_OUT_EN
      chk($sformatf("rst_line%0d", i), lin[i], 0);
`endif
      sq[i].delete();
      cap[i].delete();
      mark_m[i] = 1'b0;
      dval[i] = 1'b0;
      din[i] = 8'h00;
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    mon_en = 1'b1;
  endtask

  // Offers b; while not ready, data_in/data_valid carry junk that must be ignored
  task automatic send(int i, logic [7:0] b);
    int n = 0;
    dval[1 - i] = 1'b0;
    forever begin
      din[i]  = b;
      dval[i] = 1'b1;
      if (drdy[i]) begin
        push_byte(i, b);
        @(negedge clk); #1;
        return;
      end
      din[i]  = 8'($urandom);
      dval[i] = 1'($urandom);
      @(negedge clk); #1;
      n++;
      if (n > 200) begin
        chk($sformatf("send_timeout%0d", i), 0, 1);
        return;
      end
    end
  endtask

  task automatic idle_gap(int i);
    int n = 0;
    dval[i] = 1'b0;
    while (!drdy[i] && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 200) chk($sformatf("gap_timeout%0d", i), 0, 1);
    @(negedge clk); #1;
  endtask

  task automatic wait_idle(int i);
    int n = 0;
    dval[i] = 1'b0;
    while ((sq[i].size() != 0 || evld[i]) && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 2000) chk($sformatf("idle_timeout%0d", i), 0, 1);
    @(negedge clk); #1;
  endtask

  // exp holds up to 16 symbols, first symbol in the top two bits
  task automatic check_cap(int i, int nsym, logic [31:0] exp);
    chk($sformatf("cap_len%0d", i), cap[i].size(), nsym * bd(i));
    if (cap[i].size() == nsym * bd(i)) begin
      for (int k = 0; k < nsym; k++)
        for (int c = 0; c < bd(i); c++)
          chk($sformatf("cap%0d_sym%0d_clk%0d", i, k, c), cap[i][k * bd(i) + c], exp[31 - 2 * k -: 2]);
    end
    cap[i].delete();
  endtask

  initial begin
    int i;
    int r;
    for (int k = 0; k < 2; k++) begin
      din[k]  = 8'h00;
      dval[k] = 1'b0;
    end
    @(negedge clk); #1;
    do_reset();

    send(0, 8'hA5);
    wait_idle(0);
    check_cap(0, 8, {16'hD174, 16'h0000});

    send(0, 8'hFF);
    send(0, 8'h80);
    wait_idle(0);
    check_cap(0, 16, {16'hCCCC, 16'hD555});

    send(1, 8'h01);
    wait_idle(1);
    check_cap(1, 8, {16'hD555, 16'h0000});

    do_reset();
    send(0, 8'h0F);
    idle_gap(0);
    send(0, 8'h01);
    wait_idle(0);
    check_cap(0, 16, {16'h55CC, 16'h5557});

    send(0, 8'hF0);
    repeat (13) begin
      @(negedge clk); #1;
    end
    do_reset();
    send(0, 8'h80);
    wait_idle(0);
    check_cap(0, 8, {16'hD555, 16'h0000});

    for (int n = 0; n < 48; n++) begin
      i = int'($urandom_range(0, 1));
      send(i, 8'($urandom));
      r = int'($urandom_range(0, 2));
      if (r == 1) idle_gap(i);
      else if (r == 2) begin
        wait_idle(i);
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk); #1;
        end
      end
    end
    wait_idle(0);
    wait_idle(1);
    cap[0].delete();
    cap[1].delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
